// File: rtl/residual_seq_ctrl.sv
// -----------------------------------------------------------------------------
// residual_seq_ctrl
//
// Sequential residual engine. A start request in IDLE takes one LOAD cycle to
// snapshot both input vectors. It then spends M RUN cycles. Each RUN cycle
// produces one element of residual = x_theta - y, using 32-bit wrap-around.
// A single DONE cycle follows, with a one-cycle done pulse.
//
// Optional feature (macro RESIDUAL_SSE_EN):
//   defined   -> sse accumulates the sum of squared residuals, modulo 2^64.
//   undefined -> sse is tied to 0 and no multiplier is built.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   start     : pass request, sampled only in IDLE
//   x_theta   : M x 32-bit signed prediction vector; element i at
//               [32*M-1-32*i -: 32]
//   y         : M x 32-bit signed target vector; same packing as x_theta
//   residual  : registered x_theta - y; same packing as x_theta
//   busy      : high in LOAD and RUN
//   done      : one-cycle pulse in DONE
//   idx       : element index being processed in RUN; reads 0 elsewhere
//   ovf       : sticky per pass; set on any signed subtraction overflow
//   sse       : sum of squared residuals (0 when the feature is disabled)
// -----------------------------------------------------------------------------
module residual_seq_ctrl #(
    parameter int M = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [32*M-1:0]               x_theta,
    input  logic [32*M-1:0]               y,
    output logic [32*M-1:0]               residual,
    output logic                          busy,
    output logic                          done,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] idx,
    output logic                          ovf,
    output logic [63:0]                   sse
);

    // M == 1 would give a zero-width index, so the index is kept at least 1 bit.
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic signed [31:0] x_elem     [M];
    logic signed [31:0] y_elem     [M];
    logic signed [31:0] x_snap_reg [M];
    logic signed [31:0] y_snap_reg [M];
    logic signed [31:0] res_reg    [M];
    logic [IW-1:0]      idx_reg;
    logic               ovf_reg;

    logic signed [31:0] cur_x;
    logic signed [31:0] cur_y;
    logic signed [31:0] diff;
    logic               elem_ovf;
    logic               last_elem;

    // Unpack the input vectors and pack the result vector. Element 0 sits in
    // the most significant word.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_elem
            assign x_elem[gi] = x_theta[32*M-1-32*gi -: 32];
            assign y_elem[gi] = y[32*M-1-32*gi -: 32];
            assign residual[32*M-1-32*gi -: 32] = res_reg[gi];
        end
    endgenerate

    assign cur_x     = x_snap_reg[idx_reg];
    assign cur_y     = y_snap_reg[idx_reg];
    assign diff      = cur_x - cur_y;
    // Overflow only occurs when the operand signs differ. In that case a
    // result sign that disagrees with the minuend sign means the result wrapped.
    assign elem_ovf  = (cur_x[31] != cur_y[31]) && (diff[31] != cur_x[31]);
    assign last_elem = (idx_reg == IW'(M - 1));

    // Next-state and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_elem) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: snapshot, per-element result, index, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                x_snap_reg[i] <= '0;
                y_snap_reg[i] <= '0;
                res_reg[i]    <= '0;
            end
            idx_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    for (int i = 0; i < M; i++) begin
                        x_snap_reg[i] <= x_elem[i];
                        y_snap_reg[i] <= y_elem[i];
                        res_reg[i]    <= '0;
                    end
                    idx_reg <= '0;
                    ovf_reg <= 1'b0;
                end
                RUN: begin
                    res_reg[idx_reg] <= diff;
                    ovf_reg          <= ovf_reg | elem_ovf;
                    // Wrap back to 0 on the last element so idx reads 0 in DONE.
                    idx_reg          <= last_elem ? '0 : idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign idx = idx_reg;
    assign ovf = ovf_reg;

`ifdef RESIDUAL_SSE_EN
    logic [63:0]        sse_reg;
    logic signed [63:0] diff_ext;
    logic signed [63:0] diff_sq;

    assign diff_ext = 64'(diff);          // sign-extend the residual
    assign diff_sq  = diff_ext * diff_ext; // low 64 bits; the sum wraps mod 2^64

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sse_reg <= '0;
        end else begin
            case (state_reg)
                LOAD:    sse_reg <= '0;
                RUN:     sse_reg <= sse_reg + 64'(diff_sq);
                default: ;
            endcase
        end
    end

    assign sse = sse_reg;
`else
    assign sse = '0;
`endif

endmodule

// File: tb/tb_residual_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_residual_seq_ctrl
//
// Scoreboard bench for residual_seq_ctrl with M = 4. The stimulus tasks push
// one expected result per pass into a queue. A separate monitor pops one entry
// on every done pulse. It checks each residual element, ovf, sse and the
// start-to-done latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_residual_seq_ctrl;

    localparam int M = 4;
    localparam int W = 32 * M;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  x_theta = '0;
    logic [W-1:0]  y = '0;
    logic [W-1:0]  residual;
    logic          busy;
    logic          done;
    logic [1:0]    idx;
    logic          ovf;
    logic [63:0]   sse;

    residual_seq_ctrl #(.M(M)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x_theta  (x_theta),
        .y        (y),
        .residual (residual),
        .busy     (busy),
        .done     (done),
        .idx      (idx),
        .ovf      (ovf),
        .sse      (sse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic [63:0]  sse;
        int           start_cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] el(input logic [W-1:0] v, input int i);
        return v[W-1-32*i -: 32];
    endfunction

    function automatic logic [W-1:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [63:0] sse_of(input logic [63:0] full);
`ifdef RESIDUAL_SSE_EN
        return full;
`else
        return (full & 64'd0);
`endif
    endfunction

    // Monitor: every done pulse must match the oldest expected pass.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < M; i++) begin
                    check($sformatf("%s_res%0d", mon_e.name, i), 64'(el(residual, i)),
                          64'(el(mon_e.res, i)));
                end
                check({mon_e.name, "_ovf"}, 64'(ovf), 64'(mon_e.ovf));
                check({mon_e.name, "_sse"}, sse, mon_e.sse);
                // Start set before edge start_cyc+1; the DONE cycle is the (M+2)th cycle.
                check({mon_e.name, "_latency"}, 64'(cyc - mon_e.start_cyc), 64'(M + 2));
                $display("txn %s: done at cycle %0d, residual=%h ovf=%0b sse=%0d",
                         mon_e.name, cyc, residual, ovf, sse);
            end
        end
    end

    // Wait for done, bounded. When scramble is set, the inputs change every RUN cycle.
    task automatic wait_done(input bit scramble);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else if (scramble) begin
                x_theta = {$urandom, $urandom, $urandom, $urandom};
                y       = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        check("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic push_exp(input string name, input logic [W-1:0] r, input logic o,
                            input logic [63:0] s_full, input int sc);
        exp_t e;
        e.res = r; e.ovf = o; e.sse = sse_of(s_full); e.start_cyc = sc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic run_pass(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input logic [W-1:0] r, input logic o, input logic [63:0] s_full,
                            input bit scramble);
        @(negedge clk);
        x_theta = xv;
        y       = yv;
        start   = 1'b1;
        push_exp(name, r, o, s_full, cyc);
        @(negedge clk);
        start = 1'b0;
        wait_done(scramble);
    endtask

    logic [W-1:0] s1_x, s1_y, s1_r;
    bit           seen2;

    initial begin
        s1_x = pack4(32'd10, 32'd20, 32'd30, 32'd40);
        s1_y = pack4(32'd1, 32'd2, 32'd3, 32'd4);
        s1_r = pack4(32'd9, 32'd18, 32'd27, 32'd36);

        // Reset state with busy inputs present
        x_theta = s1_x;
        y       = s1_y;
        start   = 1'b1;
        #1;
        check("rst_residual", 64'(residual), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_idx", 64'(idx), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_sse", sse, 64'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: basic pass
        run_pass("s1", s1_x, s1_y, s1_r, 1'b0, 64'd2430, 1'b0);

        // Scenario 2: signed overflow in element 0, then results held
        run_pass("s2",
                 pack4(32'h7FFF_FFFF, 32'd5, -32'sd7, 32'd0),
                 pack4(-32'sd1, 32'd10, 32'd3, 32'd0),
                 pack4(32'h8000_0000, -32'sd5, -32'sd10, 32'd0),
                 1'b1, 64'd4611686018427388029, 1'b0);
        repeat (3) @(negedge clk);
        check("s2_ovf_hold", 64'(ovf), 64'd1);
        check("s2_res0_hold", 64'(el(residual, 0)), 64'h8000_0000);
        check("idle_idx", 64'(idx), 64'd0);

        // Scenario 6: equal vectors clear the previous ovf and give zero
        run_pass("s6", {M{-32'sd5}}, {M{-32'sd5}}, '0, 1'b0, 64'd0, 1'b0);

        // Scenario 3: inputs scrambled during RUN must not disturb the pass
        run_pass("s3",
                 pack4(32'd100, -32'sd200, 32'd300, -32'sd400),
                 pack4(32'd50, 32'd50, 32'd50, 32'd50),
                 pack4(32'd50, -32'sd250, 32'd250, -32'sd450),
                 1'b0, 64'd330000, 1'b1);

        // Scenario 4: start held high gives back-to-back passes with one IDLE gap
        @(negedge clk);
        x_theta = s1_x;
        y       = s1_y;
        start   = 1'b1;
        push_exp("s4a", s1_r, 1'b0, 64'd2430, cyc);
        wait_done(1'b0);
        push_exp("s4b", s1_r, 1'b0, 64'd2430, cyc + 1);
        @(negedge clk);
        check("s4_gap_busy", 64'(busy), 64'd0);
        check("s4_gap_done", 64'(done), 64'd0);
        @(negedge clk);
        check("s4_reload_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(1'b0);

        // Scenario 5: reset mid-RUN at idx == 2 aborts with no done pulse
        @(negedge clk);
        x_theta = s1_x;
        y       = s1_y;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen2 = 1'b0;
        for (int k = 0; k < 20 && !seen2; k++) begin
            @(negedge clk);
            if (idx == 2'd2) seen2 = 1'b1;
        end
        check("s5_reach_idx2", 64'(seen2), 64'd1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_residual", 64'(residual), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        check("s5_rst_done", 64'(done), 64'd0);
        check("s5_rst_idx", 64'(idx), 64'd0);
        check("s5_rst_ovf", 64'(ovf), 64'd0);
        check("s5_rst_sse", sse, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_pass("s5_after", s1_x, s1_y, s1_r, 1'b0, 64'd2430, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
